// File: rtl/regwb_arbiter.sv
// Register-file write-back arbiter: ALU results win every cycle, loads wait in a
// DEPTH-entry squashable FIFO. Define REGWB_BYPASS_EN to let a load skip an empty FIFO.
module regwb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        AluValid,
  input  logic [4:0]  AluReg,
  input  logic [31:0] AluData,
  input  logic        LoadValid,
  output logic        LoadReady,
  input  logic [4:0]  LoadReg,
  input  logic [31:0] LoadData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        Hazard1,
  output logic        Hazard2,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]       q_reg_q  [DEPTH];
  logic [31:0]      q_data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_reg_q, wr_reg_d;
  logic [31:0]      wr_data_q, wr_data_d;

  logic             load_xfer, push, pop, bypass, alu_live;
  logic [DEPTH-1:0] squash, hit1, hit2;

  assign LoadReady = (count_q < FULL);
  assign load_xfer = LoadValid && LoadReady;
  assign pop       = !AluValid && (count_q != '0);
  assign alu_live  = AluValid && (AluReg != 5'd0);

`ifdef REGWB_BYPASS_EN
  assign bypass = load_xfer && (count_q == '0) && !AluValid;
`else
  assign bypass = 1'b0;
`endif
  assign push = load_xfer && !bypass;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign squash[gi] = alu_live && (q_reg_q[gi] == AluReg);
      assign hit1[gi]   = vld_q[gi] && (q_reg_q[gi] == ReadRegister1);
      assign hit2[gi]   = vld_q[gi] && (q_reg_q[gi] == ReadRegister2);
    end
  endgenerate

  assign Hazard1 = (ReadRegister1 != 5'd0) &&
                   ((wr_en_q && (wr_reg_q == ReadRegister1)) || (|hit1));
  assign Hazard2 = (ReadRegister2 != 5'd0) &&
                   ((wr_en_q && (wr_reg_q == ReadRegister2)) || (|hit2));

  always_comb begin
    vld_d   = vld_q & ~squash;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + PW'(1);
    end
    // A load pushed alongside a matching ALU write is already stale.
    if (push) begin
      vld_d[wptr_q] = (LoadReg != 5'd0) && !(alu_live && (LoadReg == AluReg));
      wptr_d        = wptr_q + PW'(1);
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (AluValid) begin
      wr_en_d   = (AluReg != 5'd0);
      wr_reg_d  = AluReg;
      wr_data_d = AluData;
    end else if (bypass) begin
      wr_en_d   = (LoadReg != 5'd0);
      wr_reg_d  = LoadReg;
      wr_data_d = LoadData;
    end else if (pop) begin
      wr_en_d   = vld_q[rptr_q];
      wr_reg_d  = q_reg_q[rptr_q];
      wr_data_d = q_data_q[rptr_q];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= 5'd0;
      wr_data_q <= 32'd0;
    end else begin
      vld_q     <= vld_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge Clk) begin
    if (push) begin
      q_reg_q[wptr_q]  <= LoadReg;
      q_data_q[wptr_q] <= LoadData;
    end
  end

  assign RegWrite      = wr_en_q;
  assign WriteRegister = wr_reg_q;
  assign WriteData     = wr_data_q;
endmodule
